ddr3_mport_arbit: RTL and testbench
===================================

DDR3_MPORT_ARBIT -- requirements
Module: ddr3_mport_arbit

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of user channels (1..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, MIG app data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 28, MIG app address width.
REQ-004 SHALL have parameter BURST_LEN, default 64, app commands per grant.
REQ-005 SHALL have parameter ADDR_STEP, default 8, address increment per app command.
REQ-006 Port clk, input, 1, the only clock (MIG ui_clk); all logic is on its rising edge.
REQ-007 Port rst, input, 1, reset: synchronous, active-high (driven from ui_clk_sync_rst).
REQ-008 Port init_calib_complete, input, 1, MIG calibration done.
REQ-009 Port ch_wr_req, input, NUM_CH, level: channel write FIFO holds >= BURST_LEN words.
REQ-010 Port ch_rd_req, input, NUM_CH, level: channel read FIFO has room for >= BURST_LEN words.
REQ-011 Port ch_ptr_rst, input, NUM_CH, pulse: reload both channel pointers to their begin addresses.
REQ-012 Port ch_wr_addr_begin / ch_wr_addr_end, input, NUM_CH*ADDR_WIDTH each, packed write region (end inclusive).
REQ-013 Port ch_rd_addr_begin / ch_rd_addr_end, input, NUM_CH*ADDR_WIDTH each, packed read region (end inclusive).
REQ-014 Port ch_wr_data, input, NUM_CH*DATA_WIDTH, packed FWFT write-FIFO heads.
REQ-015 Port ch_wr_data_rd, output, NUM_CH, one-hot pop strobe for the write FIFO heads.
REQ-016 Port ch_rd_data, output, DATA_WIDTH, registered read data, shared by all channels.
REQ-017 Port ch_rd_data_vld, output, NUM_CH, one-hot: ch_rd_data belongs to this channel.
REQ-018 Ports app_en, app_cmd[2:0], app_addr[ADDR_WIDTH], app_wdf_wren, app_wdf_end, app_wdf_data[DATA_WIDTH], app_wdf_mask[DATA_WIDTH/8] SHALL be outputs to the MIG.
REQ-019 Ports app_rdy, app_wdf_rdy, app_rd_data[DATA_WIDTH], app_rd_data_valid SHALL be inputs from the MIG.

Function
REQ-020 FSM states: IDLE, ARB, WRITE, READ, DRAIN; IDLE->ARB once init_calib_complete=1.
REQ-021 Requester vector is 2*NUM_CH wide, index 2*ch = write, 2*ch+1 = read; ARB grants one requester per cycle by round-robin.
REQ-022 Round-robin search SHALL start at last_grant+1 modulo 2*NUM_CH; last_grant = 2*NUM_CH-1 after reset, so index 0 wins first.
REQ-023 ARB with no request SHALL stay in ARB; a grant moves to WRITE or READ on the next cycle and latches channel and direction.
REQ-024 WRITE: app_en=app_wdf_wren=app_wdf_end=1, app_cmd=3'b000, app_wdf_data = granted ch_wr_data slice, app_wdf_mask=0.
REQ-025 A write beat completes only in a cycle with app_rdy=1 AND app_wdf_rdy=1; ch_wr_data_rd for the granted channel pulses in that same cycle only.
REQ-026 READ: app_en=1, app_cmd=3'b001; a command completes on app_rdy=1.
REQ-027 Each completed command SHALL advance the channel pointer: ptr+ADDR_STEP, or begin if ptr+ADDR_STEP > end (wrap).
REQ-028 After BURST_LEN completed commands: WRITE->ARB; READ->DRAIN.
REQ-029 DRAIN SHALL exit to ARB when BURST_LEN app_rd_data_valid beats for the burst have been counted; valids arriving during READ count too.
REQ-030 Each app_rd_data_valid beat SHALL appear on ch_rd_data with ch_rd_data_vld one-hot for the latched channel exactly 1 cycle later.
REQ-031 app_en SHALL be 0 in IDLE, ARB and DRAIN; app_addr = granted pointer while app_en=1.
REQ-032 ch_ptr_rst on an idle channel reloads its pointers next cycle; on the granted channel it is held pending and applied after the burst ends, overriding that burst's last advance.
REQ-033 Request changes during a burst SHALL NOT shorten or abort the burst.
REQ-034 Beat and outstanding-read counters SHALL be clog2(BURST_LEN)+1 bits and SHALL NOT overflow.

Reset
REQ-035 While rst=1 at a clock edge: FSM=IDLE, all counters 0, last_grant=2*NUM_CH-1, pending ptr_rst cleared.
REQ-036 While rst=1 at a clock edge: every output 0 (app_en, app_wdf_wren, app_wdf_end, ch_wr_data_rd, ch_rd_data_vld, ch_rd_data, app_addr, app_cmd).
REQ-037 While rst=1 at a clock edge: each pointer loads its begin address; reset mid-burst abandons the burst without further app_en.

Structure
REQ-038 Package ddr3_arbit_pkg SHALL hold the FSM state encoding and CMD_WR=3'b000, CMD_RD=3'b001.
REQ-039 Sub-module rr_arbiter (parameter N, inputs req[N] and last[clog2 N], output one-hot grant) SHALL implement REQ-022.

Verification
REQ-040 NUM_CH=2, BURST_LEN=4: ch0 write held -> exactly 4 app_en write beats at addrs 0,8,16,24, then 4 ch_wr_data_rd pulses on ch0.
REQ-041 All four requesters held -> grant order w0,r0,w1,r1,w0, with no requester granted twice before the others.
REQ-042 app_wdf_rdy toggling 1,0,1 during WRITE -> beat and FIFO pop occur only when both rdy are 1.
REQ-043 wr region 0..24, two write bursts -> second burst starts at address 0 (wrap).
REQ-044 READ burst with valids delayed 20 cycles -> FSM holds in DRAIN, ch_rd_data_vld one-hot on ch1 one cycle after each valid, then returns to ARB.
REQ-045 rst asserted mid-WRITE -> next cycle all outputs 0 and state IDLE; after reset the first burst starts at begin.

Source files
------------

// File: rtl/ddr3_arbit_pkg.sv
// Shared definitions for the multi-port DDR3 (MIG app interface) arbiter:
// FSM state encoding and the MIG app command codes.
package ddr3_arbit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

endpackage

// File: rtl/ddr3_mport_arbit_rr.sv
// Round-robin arbiter: the search starts one past the last granted index and
// wraps modulo N, so the most recently served requester has lowest priority.
module rr_arbiter #(
    parameter int N  = 8,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] last,
    output logic [N-1:0]  grant
);

    // first active request found walking forward from last+1
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr3_mport_arbit.sv
// Multi-port arbiter in front of a MIG app interface. Each user channel has a
// write and a read requester; a granted requester owns the app interface for
// BURST_LEN commands, walking a per-channel circular address region.
module ddr3_mport_arbit
    import ddr3_arbit_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 28,
    parameter int BURST_LEN  = 64,
    parameter int ADDR_STEP  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           init_calib_complete,
    input  logic [NUM_CH-1:0]              ch_wr_req,
    input  logic [NUM_CH-1:0]              ch_rd_req,
    input  logic [NUM_CH-1:0]              ch_ptr_rst,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_wr_addr_begin,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_wr_addr_end,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_rd_addr_begin,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   ch_rd_addr_end,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_wr_data,
    output logic [NUM_CH-1:0]              ch_wr_data_rd,
    output logic [DATA_WIDTH-1:0]          ch_rd_data,
    output logic [NUM_CH-1:0]              ch_rd_data_vld,
    output logic                           app_en,
    output logic [2:0]                     app_cmd,
    output logic [ADDR_WIDTH-1:0]          app_addr,
    output logic                           app_wdf_wren,
    output logic                           app_wdf_end,
    output logic [DATA_WIDTH-1:0]          app_wdf_data,
    output logic [DATA_WIDTH/8-1:0]        app_wdf_mask,
    input  logic                           app_rdy,
    input  logic                           app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]          app_rd_data,
    input  logic                           app_rd_data_valid
);

    localparam int NREQ = 2 * NUM_CH;
    localparam int GW   = $clog2(NREQ);
    localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW   = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] BEAT_FULL = CW'(BURST_LEN);

    state_e                 state_q, state_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic [CW-1:0]          beat_q, beat_d;
    logic [CW-1:0]          rdv_q, rdv_d;

    logic [ADDR_WIDTH-1:0]  wr_ptr_q [NUM_CH];
    logic [ADDR_WIDTH-1:0]  rd_ptr_q [NUM_CH];
    logic [NUM_CH-1:0]      pend_q;

    logic [DATA_WIDTH-1:0]  ch_rd_data_q;
    logic [NUM_CH-1:0]      ch_rd_data_vld_q;

    logic [ADDR_WIDTH-1:0]  wr_beg [NUM_CH];
    logic [ADDR_WIDTH-1:0]  wr_fin [NUM_CH];
    logic [ADDR_WIDTH-1:0]  rd_beg [NUM_CH];
    logic [ADDR_WIDTH-1:0]  rd_fin [NUM_CH];
    logic [DATA_WIDTH-1:0]  wr_head [NUM_CH];

    logic [NREQ-1:0]        req_vec;
    logic [NREQ-1:0]        grant_vec;
    logic                   grant_any;
    logic [GW-1:0]          grant_idx;

    logic                   wr_done;
    logic                   rd_done;
    logic                   drain_done;
    logic                   burst_active;
    logic                   burst_end;

    // unpack the per-channel buses and interleave write/read requesters
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign wr_beg[gi]         = ch_wr_addr_begin[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_fin[gi]         = ch_wr_addr_end[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_beg[gi]         = ch_rd_addr_begin[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_fin[gi]         = ch_rd_addr_end[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wr_head[gi]        = ch_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign req_vec[2*gi]      = ch_wr_req[gi];
        assign req_vec[2*gi + 1]  = ch_rd_req[gi];
    end

    rr_arbiter #(
        .N  (NREQ),
        .LW (GW)
    ) u_rr (
        .req   (req_vec),
        .last  (last_grant_q),
        .grant (grant_vec)
    );

    // encode the one-hot grant into a requester index
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_vec[i]) grant_idx = GW'(i);
        end
    end

    assign grant_any    = |grant_vec;
    assign wr_done      = (state_q == ST_WRITE) && app_rdy && app_wdf_rdy;
    assign rd_done      = (state_q == ST_READ) && app_rdy;
    // the last valid can land in the same cycle the check is made
    assign drain_done   = (rdv_q == BEAT_FULL) || ((rdv_q == BEAT_LAST) && app_rd_data_valid);
    assign burst_active = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign burst_end    = (wr_done && (beat_q == BEAT_LAST)) || ((state_q == ST_DRAIN) && drain_done);

    // pointer step with wrap back to begin once the inclusive end is passed
    function automatic logic [ADDR_WIDTH-1:0] next_ptr(
        input logic [ADDR_WIDTH-1:0] ptr,
        input logic [ADDR_WIDTH-1:0] beg,
        input logic [ADDR_WIDTH-1:0] fin
    );
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, ptr} + (ADDR_WIDTH+1)'(ADDR_STEP);
        return (sum > {1'b0, fin}) ? beg : sum[ADDR_WIDTH-1:0];
    endfunction

    // next-state logic: arbitration, beat counting, read-valid accounting
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ch_d         = ch_q;
        beat_d       = beat_q;
        rdv_d        = rdv_q;
        if (((state_q == ST_READ) || (state_q == ST_DRAIN)) && app_rd_data_valid &&
            (rdv_q != BEAT_FULL)) begin
            rdv_d = rdv_q + 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (init_calib_complete) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (grant_any) begin
                    last_grant_d = grant_idx;
                    ch_d         = CHW'(grant_idx >> 1);
                    beat_d       = '0;
                    rdv_d        = '0;
                    state_d      = grant_idx[0] ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_done) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) state_d = ST_ARB;
                end
            end
            ST_READ: begin
                if (rd_done) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) state_d = ST_ARB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            ch_q         <= '0;
            beat_q       <= '0;
            rdv_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ch_q         <= ch_d;
            beat_q       <= beat_d;
            rdv_q        <= rdv_d;
        end
    end

    // per-channel address pointers; a reload request on the busy channel waits for burst end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_beg[c];
                rd_ptr_q[c] <= rd_beg[c];
            end
            pend_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (burst_active && (ch_q == CHW'(c))) begin
                    if (burst_end && (pend_q[c] || ch_ptr_rst[c])) begin
                        wr_ptr_q[c] <= wr_beg[c];
                        rd_ptr_q[c] <= rd_beg[c];
                        pend_q[c]   <= 1'b0;
                    end else begin
                        pend_q[c] <= pend_q[c] | ch_ptr_rst[c];
                        if (wr_done) wr_ptr_q[c] <= next_ptr(wr_ptr_q[c], wr_beg[c], wr_fin[c]);
                        if (rd_done) rd_ptr_q[c] <= next_ptr(rd_ptr_q[c], rd_beg[c], rd_fin[c]);
                    end
                end else if (ch_ptr_rst[c] || pend_q[c]) begin
                    wr_ptr_q[c] <= wr_beg[c];
                    rd_ptr_q[c] <= rd_beg[c];
                    pend_q[c]   <= 1'b0;
                end
            end
        end
    end

    // read return path: one-cycle register tagged with the latched channel
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_rd_data_q     <= '0;
            ch_rd_data_vld_q <= '0;
        end else begin
            ch_rd_data_vld_q <= '0;
            if (app_rd_data_valid) begin
                ch_rd_data_q           <= app_rd_data;
                ch_rd_data_vld_q[ch_q] <= 1'b1;
            end
        end
    end

    assign ch_rd_data     = ch_rd_data_q;
    assign ch_rd_data_vld = ch_rd_data_vld_q;

    // app-side outputs are decoded from the state so reset forces them all low
    always_comb begin
        app_en        = 1'b0;
        app_cmd       = CMD_WR;
        app_addr      = '0;
        app_wdf_wren  = 1'b0;
        app_wdf_end   = 1'b0;
        app_wdf_data  = '0;
        app_wdf_mask  = '0;
        ch_wr_data_rd = '0;
        if (state_q == ST_WRITE) begin
            app_en        = 1'b1;
            app_addr      = wr_ptr_q[ch_q];
            app_wdf_wren  = 1'b1;
            app_wdf_end   = 1'b1;
            app_wdf_data  = wr_head[ch_q];
            ch_wr_data_rd[ch_q] = wr_done;
        end else if (state_q == ST_READ) begin
            app_en   = 1'b1;
            app_cmd  = CMD_RD;
            app_addr = rd_ptr_q[ch_q];
        end
    end

endmodule

// File: tb/tb_ddr3_mport_arbit.sv
// Directed bench for ddr3_mport_arbit with two channels and 4-command bursts.
module tb_ddr3_mport_arbit;

    localparam int NUM_CH = 2;
    localparam int DW     = 32;
    localparam int AW     = 28;
    localparam int BL     = 4;
    localparam int STEP   = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 init_calib_complete;
    logic [NUM_CH-1:0]    ch_wr_req, ch_rd_req, ch_ptr_rst;
    logic [NUM_CH*AW-1:0] wr_beg, wr_end, rd_beg, rd_end;
    logic [NUM_CH*DW-1:0] ch_wr_data;
    logic [NUM_CH-1:0]    ch_wr_data_rd;
    logic [DW-1:0]        ch_rd_data;
    logic [NUM_CH-1:0]    ch_rd_data_vld;
    logic                 app_en;
    logic [2:0]           app_cmd;
    logic [AW-1:0]        app_addr;
    logic                 app_wdf_wren, app_wdf_end;
    logic [DW-1:0]        app_wdf_data;
    logic [DW/8-1:0]      app_wdf_mask;
    logic                 app_rdy, app_wdf_rdy;
    logic [DW-1:0]        app_rd_data;
    logic                 app_rd_data_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ddr3_mport_arbit #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .ADDR_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .ch_wr_req(ch_wr_req), .ch_rd_req(ch_rd_req), .ch_ptr_rst(ch_ptr_rst),
        .ch_wr_addr_begin(wr_beg), .ch_wr_addr_end(wr_end),
        .ch_rd_addr_begin(rd_beg), .ch_rd_addr_end(rd_end),
        .ch_wr_data(ch_wr_data), .ch_wr_data_rd(ch_wr_data_rd),
        .ch_rd_data(ch_rd_data), .ch_rd_data_vld(ch_rd_data_vld),
        .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid)
    );

    // reset drives every output low and IDLE ignores requests until calibrated
    task automatic test_reset();
        rst = 1'b1; init_calib_complete = 1'b0;
        ch_wr_req = '0; ch_rd_req = '0; ch_ptr_rst = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL reset_app_en got=%b exp=0", app_en); end
        checks++; if (app_wdf_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", app_wdf_wren); end
        checks++; if (ch_wr_data_rd !== 2'b00) begin failures++; $display("FAIL reset_pop got=%b exp=00", ch_wr_data_rd); end
        checks++; if (ch_rd_data_vld !== 2'b00) begin failures++; $display("FAIL reset_vld got=%b exp=00", ch_rd_data_vld); end
        checks++; if (ch_rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", ch_rd_data); end
        checks++; if (app_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", app_addr); end
        rst = 1'b0;
        ch_wr_req = 2'b01;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL idle_uncal_app_en got=%b exp=0", app_en); end
        ch_wr_req = '0;
        init_calib_complete = 1'b1;
        $display("test_reset done");
    endtask

    // one write burst; gate=1 toggles the ready inputs while the burst runs
    task automatic run_write_burst(input string tag, input int ch, input logic [AW-1:0] base, input bit gate);
        int   nbeat, npop;
        bit   started;
        logic both;
        logic [1:0] exp_pop;
        nbeat = 0; npop = 0; started = 0;
        ch_wr_req[ch] = 1'b1;
        for (int i = 0; i < 60 && nbeat < BL; i++) begin
            @(negedge clk);
            if (started) ch_wr_req[ch] = 1'b0;
            if (gate) begin
                app_wdf_rdy = (i % 2 == 0);
                app_rdy     = (i % 3 != 2);
            end
            #1;
            both    = app_en && app_rdy && app_wdf_rdy;
            exp_pop = both ? (2'b01 << ch) : 2'b00;
            if (app_en) begin
                started = 1;
                checks++; if (app_cmd !== 3'b000 || app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_wdf_mask !== '0)
                    begin failures++; $display("FAIL %s_ctrl cmd=%b wren=%b end=%b mask=%h exp cmd=000 wren=1 end=1 mask=0",
                                               tag, app_cmd, app_wdf_wren, app_wdf_end, app_wdf_mask); end
                checks++; if (app_addr !== base + AW'(nbeat * STEP))
                    begin failures++; $display("FAIL %s_addr beat=%0d got=%h exp=%h", tag, nbeat, app_addr, base + AW'(nbeat * STEP)); end
                checks++; if (app_wdf_data !== ch_wr_data[ch*DW +: DW])
                    begin failures++; $display("FAIL %s_data got=%h exp=%h", tag, app_wdf_data, ch_wr_data[ch*DW +: DW]); end
            end
            checks++; if (ch_wr_data_rd !== exp_pop)
                begin failures++; $display("FAIL %s_pop cycle=%0d got=%b exp=%b", tag, i, ch_wr_data_rd, exp_pop); end
            if (ch_wr_data_rd != 2'b00) npop++;
            if (both) nbeat++;
        end
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; ch_wr_req[ch] = 1'b0;
        checks++; if (nbeat !== BL) begin failures++; $display("FAIL %s_beats got=%0d exp=%0d", tag, nbeat, BL); end
        checks++; if (npop !== BL) begin failures++; $display("FAIL %s_pops got=%0d exp=%0d", tag, npop, BL); end
        @(negedge clk);
        #1;
        checks++; if (app_en !== 1'b0) begin failures++; $display("FAIL %s_after got app_en=%b exp=0", tag, app_en); end
        $display("%s burst ch=%0d base=%h beats=%0d", tag, ch, base, nbeat);
    endtask

    task automatic test_write_burst();
        run_write_burst("wr_burst", 0, 28'h0, 1'b0);
    endtask

    task automatic test_wrap();
        run_write_burst("wr_wrap", 0, 28'h0, 1'b0);
    endtask

    task automatic test_rdy_gating();
        run_write_burst("wr_gate", 1, 28'h200, 1'b1);
    endtask

    // ch1 read burst, valids arrive 20 cycles late; DRAIN must hold off a pending write
    task automatic test_read_drain();
        int s, nrd, nvld, v, k;
        bit wr_seen;
        logic prev_v;
        logic [DW-1:0] prev_d;
        s = -1; nrd = 0; nvld = 0; v = -1; k = 0; wr_seen = 0; prev_v = 1'b0; prev_d = '0;
        ch_rd_req[1] = 1'b1;
        for (int i = 0; i < 80 && !wr_seen; i++) begin
            @(negedge clk);
            if (s >= 0) ch_rd_req[1] = 1'b0;
            if (s >= 0 && i == s + 5) ch_wr_req[0] = 1'b1;
            k = i - s;
            app_rd_data_valid = (s >= 0) && (k == 20 || k == 21 || k == 23 || k == 24);
            app_rd_data = 32'hD000_0000 + DW'(k);
            #1;
            checks++; if (ch_rd_data_vld !== (prev_v ? 2'b10 : 2'b00))
                begin failures++; $display("FAIL rd_vld cycle=%0d got=%b exp=%b", i, ch_rd_data_vld, prev_v ? 2'b10 : 2'b00); end
            if (prev_v) begin
                checks++; if (ch_rd_data !== prev_d)
                    begin failures++; $display("FAIL rd_data cycle=%0d got=%h exp=%h", i, ch_rd_data, prev_d); end
            end
            if (app_en) begin
                if (s < 0) s = i;
                if (nrd < BL) begin
                    checks++; if (app_cmd !== 3'b001 || app_addr !== 28'h300 + AW'(nrd * STEP))
                        begin failures++; $display("FAIL rd_cmd n=%0d got cmd=%b addr=%h exp cmd=001 addr=%h",
                                                   nrd, app_cmd, app_addr, 28'h300 + AW'(nrd * STEP)); end
                    nrd++;
                end else begin
                    wr_seen = 1;
                    checks++; if (i !== v + 2)
                        begin failures++; $display("FAIL drain_exit app_en at cycle=%0d exp=%0d", i, v + 2); end
                    checks++; if (app_cmd !== 3'b000 || app_addr !== 28'h0)
                        begin failures++; $display("FAIL drain_next got cmd=%b addr=%h exp cmd=000 addr=0", app_cmd, app_addr); end
                end
            end
            if (app_rd_data_valid) begin
                nvld++;
                if (nvld == BL) v = i;
            end
            prev_v = app_rd_data_valid;
            prev_d = app_rd_data;
        end
        checks++; if (wr_seen !== 1'b1) begin failures++; $display("FAIL drain_timeout write after drain got=%b exp=1", wr_seen); end
        checks++; if (nrd !== BL) begin failures++; $display("FAIL rd_count got=%0d exp=%0d", nrd, BL); end
        ch_wr_req[0] = 1'b0;
        app_rd_data_valid = 1'b0;
        repeat (6) @(negedge clk);
        $display("test_read_drain reads=%0d valids=%0d", nrd, nvld);
    endtask

    // reset in the middle of a write burst, then the next burst restarts at begin
    task automatic test_mid_reset();
        int nbeat;
        bit seen;
        nbeat = 0; seen = 0;
        ch_wr_req[0] = 1'b1;
        for (int i = 0; i < 30 && nbeat < 2; i++) begin
            @(negedge clk);
            #1;
            if (app_en && app_rdy && app_wdf_rdy) nbeat++;
        end
        checks++; if (nbeat !== 2) begin failures++; $display("FAIL mid_rst_setup beats got=%0d exp=2", nbeat); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || app_wdf_end !== 1'b0 || app_cmd !== 3'b000)
            begin failures++; $display("FAIL mid_rst_ctrl en=%b wren=%b end=%b cmd=%b exp all 0", app_en, app_wdf_wren, app_wdf_end, app_cmd); end
        checks++; if (ch_wr_data_rd !== 2'b00 || ch_rd_data_vld !== 2'b00 || app_addr !== '0 || ch_rd_data !== '0)
            begin failures++; $display("FAIL mid_rst_data pop=%b vld=%b addr=%h rd=%h exp all 0", ch_wr_data_rd, ch_rd_data_vld, app_addr, ch_rd_data); end
        rst = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (app_en) begin
                seen = 1;
                checks++; if (app_addr !== 28'h0 || app_cmd !== 3'b000)
                    begin failures++; $display("FAIL mid_rst_restart got addr=%h cmd=%b exp addr=0 cmd=000", app_addr, app_cmd); end
            end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL mid_rst_timeout got=%b exp=1", seen); end
        ch_wr_req = '0;
        $display("test_mid_reset restart_seen=%0b", seen);
    endtask

    // all four requesters held after reset: grants rotate w0,r0,w1,r1,w0
    task automatic test_round_robin();
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n, idx;
        logic prev_en;
        n = 0; prev_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ch_wr_req = 2'b11; ch_rd_req = 2'b11;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b1;
        for (int i = 0; i < 200 && n < 5; i++) begin
            @(negedge clk);
            #1;
            if (app_en && !prev_en) begin
                idx = ((app_addr >= 28'h200) ? 2 : 0) + ((app_cmd == 3'b001) ? 1 : 0);
                checks++; if (idx !== exp_order[n])
                    begin failures++; $display("FAIL rr_order burst=%0d got=%0d exp=%0d", n, idx, exp_order[n]); end
                $display("rr burst=%0d requester=%0d addr=%h", n, idx, app_addr);
                n++;
            end
            prev_en = app_en;
        end
        checks++; if (n !== 5) begin failures++; $display("FAIL rr_timeout bursts got=%0d exp=5", n); end
        ch_wr_req = '0; ch_rd_req = '0; app_rd_data_valid = 1'b0;
    endtask

    initial begin
        wr_beg = {28'h200, 28'h000};
        wr_end = {28'h2F8, 28'h018};
        rd_beg = {28'h300, 28'h100};
        rd_end = {28'h3F8, 28'h1F8};
        ch_wr_data = {32'hB1B1_0001, 32'hA0A0_0000};
        test_reset();
        test_write_burst();
        test_wrap();
        test_rdy_gating();
        test_read_drain();
        test_mid_reset();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
